// File: rtl/fpadd_control_if.sv
// Control/status bundle between the floating-point adder datapath and its control FSM.
// master = datapath side (raises Go, reports status); slave = fpadd_control.
interface fpadd_control_if #(
  parameter int EXPBITS      = 8,
  parameter int MANTISSABITS = 23
);
  localparam int NBITS = $clog2(MANTISSABITS);

  // Status from the datapath
  logic                    Go;
  logic                    ExpSet;
  logic [EXPBITS-1:0]      ExpDiff;
  logic                    FFOValid;
  logic [NBITS-1:0]        FFOIndex;
  logic [MANTISSABITS+1:0] Out;

  // Controls to the datapath
  logic                    SelExpMux;
  logic                    SelSRMuxL;
  logic                    SelSRMuxG;
  logic                    ShiftRightEnable;
  logic [NBITS-1:0]        ShiftRightAmount;
  logic                    SREn;
  logic                    SLEn;
  logic                    NoShift;
  logic                    IncrEn;
  logic                    DecrEn;
  logic [NBITS-1:0]        ShiftAmount;
  logic                    SelExpMuxR;
  logic                    SelManMuxR;

  modport master (
    output Go, ExpSet, ExpDiff, FFOValid, FFOIndex, Out,
    input  SelExpMux, SelSRMuxL, SelSRMuxG, ShiftRightEnable, ShiftRightAmount,
           SREn, SLEn, NoShift, IncrEn, DecrEn, ShiftAmount, SelExpMuxR, SelManMuxR
  );

  modport slave (
    input  Go, ExpSet, ExpDiff, FFOValid, FFOIndex, Out,
    output SelExpMux, SelSRMuxL, SelSRMuxG, ShiftRightEnable, ShiftRightAmount,
           SREn, SLEn, NoShift, IncrEn, DecrEn, ShiftAmount, SelExpMuxR, SelManMuxR
  );
endinterface

// File: rtl/fpadd_control.sv
// Control FSM for the FP adder: exponent alignment, normalization, rounding re-normalization.
// Optional embedded SVA checks are compiled in with `define FPADD_CONTROL_ASSERT_EN.
module fpadd_control #(
  parameter int EXPBITS      = 8,
  parameter int MANTISSABITS = 23
) (
  input  logic           Clock,
  input  logic           Reset,
  fpadd_control_if.slave bus
);
  localparam int NBITS   = $clog2(MANTISSABITS);
  localparam int SAT     = MANTISSABITS + 2;
  localparam int IDX_OVF = MANTISSABITS + 1;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ALIGN = 4'b0010,
    NORM  = 4'b0100,
    ROUND = 4'b1000
  } state_e;

  state_e state_q, state_d;
  logic   ovf;
  logic   unused_out;

  assign ovf        = bus.Out[MANTISSABITS+1];
  assign unused_out = ^bus.Out[MANTISSABITS:0];

  // Any distance beyond the mantissa plus guard bits shifts everything out anyway.
  function automatic logic [NBITS-1:0] sat_shift(input logic [EXPBITS-1:0] diff);
    if (32'(diff) > 32'(SAT)) return NBITS'(SAT);
    else                      return NBITS'(diff);
  endfunction

  function automatic logic [NBITS-1:0] left_dist(input logic [NBITS-1:0] idx);
    return NBITS'(MANTISSABITS - int'(idx));
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.Go) state_d = ALIGN;
      ALIGN:   state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   if (!ovf) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    bus.SelExpMux        = 1'b0;
    bus.SelSRMuxL        = 1'b0;
    bus.SelSRMuxG        = 1'b0;
    bus.ShiftRightEnable = 1'b0;
    bus.ShiftRightAmount = '0;
    bus.SREn             = 1'b0;
    bus.SLEn             = 1'b0;
    bus.NoShift          = 1'b0;
    bus.IncrEn           = 1'b0;
    bus.DecrEn           = 1'b0;
    bus.ShiftAmount      = '0;
    bus.SelExpMuxR       = 1'b0;
    bus.SelManMuxR       = 1'b0;
    case (state_q)
      ALIGN: begin
        bus.SelExpMux        = bus.ExpSet;
        bus.SelSRMuxG        = bus.ExpSet;
        bus.SelSRMuxL        = ~bus.ExpSet;
        bus.ShiftRightEnable = (bus.ExpDiff != '0);
        bus.ShiftRightAmount = sat_shift(bus.ExpDiff);
      end
      NORM: begin
        // Out-of-range indices fall through to NoShift rather than corrupting the exponent.
        if (bus.FFOValid && bus.FFOIndex == NBITS'(IDX_OVF)) begin
          bus.SREn        = 1'b1;
          bus.IncrEn      = 1'b1;
          bus.ShiftAmount = NBITS'(1);
        end else if (bus.FFOValid && bus.FFOIndex < NBITS'(MANTISSABITS)) begin
          bus.SLEn        = 1'b1;
          bus.DecrEn      = 1'b1;
          bus.ShiftAmount = left_dist(bus.FFOIndex);
        end else begin
          bus.NoShift     = 1'b1;
        end
      end
      ROUND: begin
        bus.SelExpMuxR = 1'b1;
        bus.SelManMuxR = 1'b1;
        if (ovf) begin
          bus.SREn        = 1'b1;
          bus.IncrEn      = 1'b1;
          bus.ShiftAmount = NBITS'(1);
        end else begin
          bus.NoShift     = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef FPADD_CONTROL_ASSERT_EN
  a_state_onehot: assert property (@(posedge Clock) disable iff (!Reset)
    $onehot(state_q));
  a_shift_mutex: assert property (@(posedge Clock) disable iff (!Reset)
    $onehot0({bus.SREn, bus.SLEn, bus.NoShift}));
  a_incdec_mutex: assert property (@(posedge Clock) disable iff (!Reset)
    !(bus.IncrEn && bus.DecrEn));
  a_align_amt_max: assert property (@(posedge Clock) disable iff (!Reset)
    32'(bus.ShiftRightAmount) <= 32'(SAT));
  a_align_to_norm: assert property (@(posedge Clock) disable iff (!Reset)
    state_q == ALIGN |=> state_q == NORM);
  a_idle_quiet: assert property (@(posedge Clock) disable iff (!Reset)
    state_q == IDLE |-> ({bus.SelExpMux, bus.SelSRMuxL, bus.SelSRMuxG, bus.ShiftRightEnable,
                          bus.ShiftRightAmount, bus.SREn, bus.SLEn, bus.NoShift, bus.IncrEn,
                          bus.DecrEn, bus.ShiftAmount, bus.SelExpMuxR, bus.SelManMuxR} == '0));
`endif

endmodule

// File: tb/tb_fpadd_control.sv
// Self-checking bench for fpadd_control: directed plan items plus randomized traffic
// compared against a phase-level reference model.
module tb_fpadd_control;
  localparam int EB = 8;
  localparam int MB = 23;

  typedef struct packed {
    logic       SelExpMux;
    logic       SelSRMuxL;
    logic       SelSRMuxG;
    logic       ShiftRightEnable;
    logic [4:0] ShiftRightAmount;
    logic       SREn;
    logic       SLEn;
    logic       NoShift;
    logic       IncrEn;
    logic       DecrEn;
    logic [4:0] ShiftAmount;
    logic       SelExpMuxR;
    logic       SelManMuxR;
  } outs_t;

  // Reference phases: 0 idle, 1 align, 2 normalize, 3 round
  localparam int PH_IDLE = 0, PH_ALIGN = 1, PH_NORM = 2, PH_ROUND = 3;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   phase  = PH_IDLE;

  fpadd_control_if #(.EXPBITS(EB), .MANTISSABITS(MB)) bus ();

  fpadd_control #(.EXPBITS(EB), .MANTISSABITS(MB)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic outs_t observe();
    outs_t o;
    o.SelExpMux        = bus.SelExpMux;
    o.SelSRMuxL        = bus.SelSRMuxL;
    o.SelSRMuxG        = bus.SelSRMuxG;
    o.ShiftRightEnable = bus.ShiftRightEnable;
    o.ShiftRightAmount = bus.ShiftRightAmount;
    o.SREn             = bus.SREn;
    o.SLEn             = bus.SLEn;
    o.NoShift          = bus.NoShift;
    o.IncrEn           = bus.IncrEn;
    o.DecrEn           = bus.DecrEn;
    o.ShiftAmount      = bus.ShiftAmount;
    o.SelExpMuxR       = bus.SelExpMuxR;
    o.SelManMuxR       = bus.SelManMuxR;
    return o;
  endfunction

  function automatic outs_t model_outs(int ph, bit es, int ed, bit fv, int fi, bit ovf);
    outs_t o = '0;
    if (ph == PH_ALIGN) begin
      o.SelExpMux        = es;
      o.SelSRMuxG        = es;
      o.SelSRMuxL        = !es;
      o.ShiftRightEnable = (ed != 0);
      o.ShiftRightAmount = 5'((ed > MB + 2) ? MB + 2 : ed);
    end else if (ph == PH_NORM) begin
      if (fv && fi == MB + 1) begin
        o.SREn = 1; o.IncrEn = 1; o.ShiftAmount = 5'd1;
      end else if (fv && fi < MB) begin
        o.SLEn = 1; o.DecrEn = 1; o.ShiftAmount = 5'(MB - fi);
      end else begin
        o.NoShift = 1;
      end
    end else if (ph == PH_ROUND) begin
      o.SelExpMuxR = 1;
      o.SelManMuxR = 1;
      if (ovf) begin
        o.SREn = 1; o.IncrEn = 1; o.ShiftAmount = 5'd1;
      end else begin
        o.NoShift = 1;
      end
    end
    return o;
  endfunction

  function automatic int next_phase(int ph, bit go, bit ovf);
    if (ph == PH_IDLE)  return go ? PH_ALIGN : PH_IDLE;
    if (ph == PH_ROUND) return ovf ? PH_ROUND : PH_IDLE;
    return ph + 1;
  endfunction

  // Called #1 after a rising edge; drives, checks at the falling edge, advances the model.
  task automatic step(input string tag, input bit go, input bit es, input logic [7:0] ed,
                      input bit fv, input logic [4:0] fi, input bit ovf);
    outs_t exp;
    bus.Go       = go;
    bus.ExpSet   = es;
    bus.ExpDiff  = ed;
    bus.FFOValid = fv;
    bus.FFOIndex = fi;
    bus.Out      = {ovf, 24'($urandom)};
    @(negedge Clock);
    exp = model_outs(phase, es, int'(ed), fv, int'(fi), ovf);
    check(tag, 32'(observe()), 32'(exp));
    @(posedge Clock);
    phase = next_phase(phase, go, ovf);
    #1;
  endtask

  task automatic reset_pulse(input string tag);
    bus.Go = 1; bus.ExpSet = 1; bus.ExpDiff = 8'd7; bus.FFOValid = 1;
    bus.FFOIndex = 5'd10; bus.Out = {2'b10, 23'h0};
    Reset = 1'b0;
    phase = PH_IDLE;
    @(negedge Clock);
    check(tag, 32'(observe()), 32'(outs_t'('0)));
    @(posedge Clock);
    @(negedge Clock);
    check({tag, "_hold"}, 32'(observe()), 32'(outs_t'('0)));
    @(posedge Clock);
    #1;
    bus.Go = 0;
    Reset = 1'b1;
  endtask

  // One full operation: idle(Go) -> align -> norm -> novf overflow rounds -> exit round.
  task automatic op(input string tag, input bit es, input logic [7:0] ed,
                    input bit fv, input logic [4:0] fi, input int novf);
    step({tag, "_go"},    1, es, ed, fv, fi, 0);
    step({tag, "_align"}, 1, es, ed, fv, fi, 1);
    step({tag, "_norm"},  1, es, ed, fv, fi, 1);
    for (int k = 0; k < novf; k++) step({tag, "_rovf"}, 1, es, ed, fv, fi, 1);
    step({tag, "_rexit"}, 0, es, ed, fv, fi, 0);
  endtask

  initial begin
    logic [7:0] ed;
    logic [4:0] fi;
    bus.Go = 0; bus.ExpSet = 0; bus.ExpDiff = '0; bus.FFOValid = 0;
    bus.FFOIndex = '0; bus.Out = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("reset_outs", 32'(observe()), 32'(outs_t'('0)));
    @(posedge Clock);
    #1;
    Reset = 1'b1;

    step("idle0", 0, 1, 8'h55, 1, 5'd24, 1);
    step("idle1", 0, 0, 8'h03, 1, 5'd21, 0);

    op("sat",     1, 8'h55, 1, 5'd24, 0);
    op("zero",    1, 8'h00, 1, 5'd23, 0);
    op("left",    1, 8'h19, 1, 5'd21, 0);
    op("novalid", 1, 8'h1a, 0, 5'd24, 0);
    op("illegal", 0, 8'h18, 1, 5'd30, 0);
    op("rnd1",    1, 8'h02, 1, 5'd24, 1);
    op("rnd2",    0, 8'h04, 1, 5'd0,  2);
    op("b2b",     0, 8'hff, 1, 5'd1,  0);

    step("mid_go", 1, 1, 8'h01, 1, 5'd22, 0);
    step("mid_align", 0, 1, 8'h01, 1, 5'd22, 0);
    reset_pulse("rst_norm");
    op("after_rst", 1, 8'h05, 1, 5'd20, 0);

    step("r_go", 1, 0, 8'h09, 1, 5'd24, 0);
    step("r_align", 0, 0, 8'h09, 1, 5'd24, 0);
    step("r_norm", 0, 0, 8'h09, 1, 5'd24, 1);
    reset_pulse("rst_round");
    op("after_rst2", 0, 8'h1b, 1, 5'd3, 1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_pulse("rand_rst");
      end else begin
        case ($urandom_range(0, 3))
          0:       ed = 8'($urandom_range(0, 30));
          1:       ed = ($urandom_range(0, 1) == 1) ? 8'd25 : 8'd26;
          default: ed = 8'($urandom);
        endcase
        fi = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(20, 26)) : 5'($urandom);
        step("rand", ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), ed,
             ($urandom_range(0, 6) != 0), fi, ($urandom_range(0, 2) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpadd_control.md
Name: fpadd_control

Overview:
- Control FSM for the IEEE-754 style floating-point adder datapath.
- Sequences three phases: exponent alignment, post-add normalization, and rounding re-normalization.
- Drives mux selects, shifter enables/amounts and exponent increment/decrement from comparator, find-first-one (FFO) and rounded-mantissa status.
- Purely control: no datapath storage beyond the state register.

Parameters:
- EXPBITS, 8, exponent width.
- MANTISSABITS, 23, stored mantissa width.
- NBITS (localparam), $clog2(MANTISSABITS) = 5, shift-amount and FFO-index width. Constraint: MANTISSABITS+2 < 2**NBITS.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Go  in  1  start request, sampled in IDLE only.
- ExpSet  in  1  1 = exponent A >= exponent B; 0 = B > A.
- ExpDiff  in  EXPBITS  |expA - expB|.
- FFOValid  in  1  sum mantissa non-zero.
- FFOIndex  in  NBITS  bit position of leading one in the sum.
- Out  in  MANTISSABITS+2  rounded mantissa; the MSB is the overflow bit.
- SelExpMux  out  1  1 = take exponent A as result exponent.
- SelSRMuxL  out  1  select of the lesser operand into the right shifter (= ~ExpSet).
- SelSRMuxG  out  1  select of the greater operand, unshifted path (= ExpSet).
- ShiftRightEnable  out  1  alignment shift active.
- ShiftRightAmount  out  NBITS  alignment shift distance.
- SREn  out  1  normalize right-shift enable.
- SLEn  out  1  normalize left-shift enable.
- NoShift  out  1  mantissa passes unshifted.
- IncrEn  out  1  exponent +1.
- DecrEn  out  1  exponent decrement by ShiftAmount.
- ShiftAmount  out  NBITS  normalize shift distance.
- SelExpMuxR  out  1  exponent mux selects the rounding loop-back.
- SelManMuxR  out  1  mantissa mux selects the rounding loop-back.

Behaviour:
- States: IDLE, ALIGN, NORM, ROUND. Reset (Reset=0, asynchronous) forces IDLE immediately, including mid-operation.
- Outputs are combinational from state and current inputs. Every output is 0 in IDLE and during reset.
- Transitions:
  - IDLE -> ALIGN when Go=1 at the clock edge.
  - ALIGN -> NORM unconditionally.
  - NORM -> ROUND unconditionally.
  - ROUND -> ROUND while Out[MANTISSABITS+1]=1; otherwise ROUND -> IDLE.
- Go is ignored outside IDLE. A new operation may start on the cycle after ROUND exits.
- ALIGN:
  - SelExpMux=ExpSet, SelSRMuxG=ExpSet, SelSRMuxL=~ExpSet.
  - ShiftRightEnable=(ExpDiff!=0).
  - ShiftRightAmount=ExpDiff, saturated to MANTISSABITS+2 when ExpDiff > MANTISSABITS+2.
  - A>B and A=B both give ExpSet=1.
- NORM (exactly one of SREn/SLEn/NoShift is high):
  - FFOValid=0: NoShift=1, IncrEn=0, DecrEn=0, ShiftAmount=0.
  - FFOIndex=MANTISSABITS+1: SREn=1, IncrEn=1, ShiftAmount=1.
  - FFOIndex=MANTISSABITS: NoShift=1, ShiftAmount=0.
  - FFOIndex<MANTISSABITS: SLEn=1, DecrEn=1, ShiftAmount=MANTISSABITS-FFOIndex.
  - FFOIndex>MANTISSABITS+1 (illegal): treated as NoShift.
- ROUND:
  - SelExpMuxR=1, SelManMuxR=1.
  - If Out[MANTISSABITS+1]=1: SREn=1, IncrEn=1, ShiftAmount=1, remain in ROUND. Repeated overflows repeat this each cycle.
  - Else: NoShift=1 and exit to IDLE.
- IncrEn and DecrEn are never high together. SREn and SLEn are never high together.
- Latency: minimum 3 cycles Go->IDLE, plus 1 per rounding overflow.

Optional Feature:
- Macro FPADD_CONTROL_ASSERT_EN.
- When defined, embedded SVA checks are compiled in, all disabled during reset:
  - state is one-hot legal;
  - SREn/SLEn/NoShift are mutually exclusive;
  - IncrEn/DecrEn are mutually exclusive;
  - ShiftRightAmount <= MANTISSABITS+2;
  - ALIGN is always followed by NORM;
  - IDLE outputs are all zero.
- When undefined: no assertions, identical functional behaviour.

Test Plan:
- Reset=0 held 2 cycles, then released -> state IDLE, all outputs 0; Go=0 keeps IDLE.
- Go=1, ExpSet=1, ExpDiff=8'h55 (A>B) -> ALIGN: SelExpMux=1, SelSRMuxG=1, SelSRMuxL=0, ShiftRightEnable=1, ShiftRightAmount=25 (saturated). ExpDiff=8'h00 -> ShiftRightEnable=0, ShiftRightAmount=0.
- NORM with FFOValid=1 and each index:
  - FFOIndex=24 -> SREn=1, IncrEn=1, ShiftAmount=1.
  - FFOIndex=23 -> NoShift=1.
  - FFOIndex=21 -> SLEn=1, DecrEn=1, ShiftAmount=2.
  - FFOValid=0 -> NoShift=1, no incr/decr.
- ROUND with Out={2'b10,23'h0} -> SREn=1, IncrEn=1, SelExpMuxR=SelManMuxR=1, stays in ROUND; next cycle Out={2'b01,...} -> NoShift=1, then IDLE.
- ROUND sequence Out=2'b10.., 2'b11.., 2'b01.. (ExpSet=0 case) -> two consecutive overflow cycles, then exit. Back-to-back Go right after exit starts a new ALIGN.
- Reset asserted in NORM or in ROUND -> immediate IDLE with all outputs 0; the next Go starts normally.
